// File: rtl/vend_ctrl.sv
// vend_ctrl: vending machine transaction controller (credit, vend, change payout, refund)
//   clk_i          system clock, all state updates on the rising edge
//   rst_ni         asynchronous reset, active-low
//   coin_valid_i   one-cycle strobe, coin present on coin_code_i
//   coin_code_i    01 = 5c, 10 = 10c, 11 = 25c, 00 = invalid
//   btn_buy_i      buy request, level sampled each cycle
//   btn_cancel_i   cancel/refund request, level sampled each cycle
//   change_ack_i   hopper has ejected the coin on change_code_o
//   drink_out_o    drink dispense enable
//   change_req_o   request to hopper to eject one coin
//   change_code_o  coin to eject, same encoding as coin_code_i
//   coin_reject_o  one-cycle strobe, inserted coin returned
//   credit_o       current credit in cents
//   state_o        one-hot: IDLE 0001, COLLECT 0010, VEND 0100, CHANGE 1000
module vend_ctrl #(
  parameter int PRICE      = 25,
  parameter int MAX_CREDIT = 95,
  parameter int TIMEOUT    = 1000,
  parameter int VEND_LEN   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_code_i,
  input  logic       btn_buy_i,
  input  logic       btn_cancel_i,
  input  logic       change_ack_i,
  output logic       drink_out_o,
  output logic       change_req_o,
  output logic [1:0] change_code_o,
  output logic       coin_reject_o,
  output logic [7:0] credit_o,
  output logic [3:0] state_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int VW = (VEND_LEN > 1) ? $clog2(VEND_LEN) : 1;
  localparam logic [8:0]    MAX9  = 9'(MAX_CREDIT);
  localparam logic [7:0]    PRICE8 = 8'(PRICE);
  localparam logic [TW-1:0] TMO   = TW'(TIMEOUT);
  localparam logic [VW-1:0] VLAST = VW'(VEND_LEN - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    COLLECT = 4'b0010,
    VEND    = 4'b0100,
    CHANGE  = 4'b1000
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    credit_q, credit_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ph_q, ph_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          drink_q, drink_d;
  logic          req_q, req_d;
  logic [1:0]    code_q, code_d;
  logic          rej_q, rej_d;
  logic [7:0]    coin_val, chg_val;
  logic [8:0]    sum;
  logic          accept, buy_ok;

  always_comb begin
    coin_val = coin_code_i == 2'b01 ? 8'd5 : coin_code_i == 2'b10 ? 8'd10 :
               coin_code_i == 2'b11 ? 8'd25 : 8'd0;
    chg_val  = code_q == 2'b01 ? 8'd5 : code_q == 2'b10 ? 8'd10 :
               code_q == 2'b11 ? 8'd25 : 8'd0;
    sum      = {1'b0, credit_q} + {1'b0, coin_val};
    // a coin arriving together with cancel is returned: the customer is asking for money back
    accept   = coin_valid_i && coin_val != 8'd0 && !btn_cancel_i &&
               (state_q == IDLE || state_q == COLLECT) && sum <= MAX9;
    buy_ok   = btn_buy_i && credit_q >= PRICE8;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmo_d    = '0;
    ph_d     = 1'b0;
    vcnt_d   = vcnt_q;
    drink_d  = drink_q;
    req_d    = req_q;
    code_d   = code_q;
    rej_d    = coin_valid_i && !accept;
    case (state_q)
      IDLE: begin
        if (accept) begin
          credit_d = sum[7:0];
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        if (btn_cancel_i) begin
          state_d = CHANGE;
        end else if (buy_ok) begin
          // buy is judged on pre-coin credit; a simultaneous coin is still credited
          credit_d = credit_q - PRICE8 + (accept ? coin_val : 8'd0);
          state_d  = VEND;
          drink_d  = 1'b1;
          vcnt_d   = '0;
        end else if (accept) begin
          credit_d = sum[7:0];
        end else if (tmo_q == TMO) begin
          state_d = CHANGE;
        end else begin
          // idle counter advances on every second idle cycle
          ph_d  = ~ph_q;
          tmo_d = tmo_q + TW'(ph_q);
        end
      end
      VEND: begin
        if (vcnt_q == VLAST) begin
          drink_d = 1'b0;
          state_d = credit_q != 8'd0 ? CHANGE : IDLE;
        end else begin
          vcnt_d = vcnt_q + VW'(1);
        end
      end
      CHANGE: begin
        if (req_q && change_ack_i) begin
          credit_d = credit_q - chg_val;
          req_d    = 1'b0;
        end else if (!req_q) begin
          // request only starts from a low cycle, giving the one-cycle gap between coins
          if (credit_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            req_d  = 1'b1;
            code_d = credit_q >= 8'd25 ? 2'b11 : credit_q >= 8'd10 ? 2'b10 : 2'b01;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      credit_q <= '0;
      tmo_q    <= '0;
      ph_q     <= 1'b0;
      vcnt_q   <= '0;
      drink_q  <= 1'b0;
      req_q    <= 1'b0;
      code_q   <= 2'b00;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      ph_q     <= ph_d;
      vcnt_q   <= vcnt_d;
      drink_q  <= drink_d;
      req_q    <= req_d;
      code_q   <= code_d;
      rej_q    <= rej_d;
    end
  end

  assign drink_out_o   = drink_q;
  assign change_req_o  = req_q;
  assign change_code_o = code_q;
  assign coin_reject_o = rej_q;
  assign credit_o      = credit_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: scoreboard bench for vend_ctrl against a transaction-level reference model
module tb_vend_ctrl;
  localparam int PRICE = 25, MAXC = 95, TMO = 10, VLEN = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       coin_valid = 1'b0, btn_buy = 1'b0, btn_cancel = 1'b0, change_ack = 1'b0;
  logic [1:0] coin_code = 2'b00;
  logic       drink_out, change_req, coin_reject;
  logic [1:0] change_code;
  logic [7:0] credit;
  logic [3:0] state;

  vend_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .TIMEOUT(TMO), .VEND_LEN(VLEN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .coin_valid_i(coin_valid), .coin_code_i(coin_code),
    .btn_buy_i(btn_buy), .btn_cancel_i(btn_cancel), .change_ack_i(change_ack),
    .drink_out_o(drink_out), .change_req_o(change_req), .change_code_o(change_code),
    .coin_reject_o(coin_reject), .credit_o(credit), .state_o(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [7:0] cr;
    logic       dr;
    logic       rq;
    logic [1:0] cd;
    logic       rj;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0, errors = 0;
  int ack_mode = 0;

  // reference model: mode 0 idle, 1 collecting, 2 dispensing, 3 paying change
  int m_mode, m_credit, m_idle, m_vleft, m_code;
  bit m_req, m_drink, m_rej;

  function automatic int val(input int c);
    return c == 1 ? 5 : c == 2 ? 10 : c == 3 ? 25 : 0;
  endfunction

  function automatic snap_t snap();
    snap_t s;
    s.st = 4'b0001 << m_mode;
    s.cr = 8'(m_credit);
    s.dr = m_drink;
    s.rq = m_req;
    s.cd = 2'(m_code);
    s.rj = m_rej;
    return s;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_credit = 0; m_idle = 0; m_vleft = 0; m_code = 0;
    m_req = 0; m_drink = 0; m_rej = 0;
  endtask

  task automatic step(input bit cv, input int cc, input bit b, input bit c, input bit a);
    int v;
    bit acc;
    v = val(cc);
    acc = cv && v != 0 && m_mode <= 1 && !c && m_credit + v <= MAXC;
    m_rej = cv && !acc;
    if (m_mode == 0) begin
      if (acc) begin m_credit += v; m_mode = 1; m_idle = 0; end
    end else if (m_mode == 1) begin
      if (c) m_mode = 3;
      else if (b && m_credit >= PRICE) begin
        m_credit = m_credit - PRICE + (acc ? v : 0);
        m_mode = 2; m_vleft = VLEN; m_drink = 1;
      end else if (acc) begin m_credit += v; m_idle = 0; end
      else if (m_idle >= 2 * TMO) m_mode = 3;
      else m_idle++;
    end else if (m_mode == 2) begin
      m_vleft--;
      if (m_vleft == 0) begin m_drink = 0; m_mode = m_credit > 0 ? 3 : 0; end
    end else begin
      if (m_req && a) begin m_credit -= val(m_code); m_req = 0; end
      else if (!m_req) begin
        if (m_credit == 0) m_mode = 0;
        else begin
          m_req = 1;
          m_code = m_credit >= 25 ? 3 : m_credit >= 10 ? 2 : 1;
        end
      end
    end
    if (m_mode != 1) m_idle = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("state", int'(state), int'(e.st));
        chk("credit", int'(credit), int'(e.cr));
        chk("drink_out", int'(drink_out), int'(e.dr));
        chk("change_req", int'(change_req), int'(e.rq));
        chk("change_code", int'(change_code), int'(e.cd));
        chk("coin_reject", int'(coin_reject), int'(e.rj));
      end
    end
  end

  task automatic apply(input bit cv, input int cc, input bit b, input bit c);
    bit a;
    a = ack_mode == 0 ? 1'b1 : ack_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    coin_valid = cv; coin_code = 2'(cc); btn_buy = b; btn_cancel = c; change_ack = a;
    step(cv, cc, b, c, a);
    exp_q.push_back(snap());
  endtask

  task automatic cyc(input bit cv, input int cc, input bit b, input bit c);
    @(negedge clk);
    apply(cv, cc, b, c);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask

  task automatic coin(input int cc);
    cyc(1, cc, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    coin_valid = 0; coin_code = 0; btn_buy = 0; btn_cancel = 0; change_ack = 0;
    #1;
    chk("rst_state", int'(state), 1);
    chk("rst_credit", int'(credit), 0);
    chk("rst_drink", int'(drink_out), 0);
    chk("rst_req", int'(change_req), 0);
    chk("rst_code", int'(change_code), 0);
    chk("rst_reject", int'(coin_reject), 0);
    model_reset();
    exp_q.push_back(snap());
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 0);
  endtask

  initial begin
    int pc, pb, pn;
    model_reset();
    do_reset();
    ack_mode = 0;
    coin(3); cyc(0, 0, 1, 0); idle(8);
    coin(1); coin(2); coin(3); cyc(0, 0, 1, 0); idle(16);
    coin(2); coin(2); cyc(0, 0, 1, 0); idle(2); cyc(0, 0, 0, 1); idle(10);
    coin(3); coin(3); coin(3); coin(2); coin(1); coin(2); coin(0); cyc(0, 0, 0, 1); idle(20);
    coin(3); coin(1); cyc(0, 0, 1, 1); idle(12);
    coin(3); coin(3); cyc(1, 2, 1, 0); idle(20);
    coin(2); cyc(1, 1, 0, 1); idle(10);
    cyc(1, 3, 0, 1); idle(2);
    coin(2); coin(1); ack_mode = 2; idle(2 * TMO + 6);
    do_reset();
    for (int b = 0; b < 30; b++) begin
      ack_mode = 1;
      pc = b % 2 ? 30 : 3;
      pb = b % 2 ? 15 : 3;
      pn = b % 2 ? 5 : 1;
      repeat (100)
        cyc($urandom_range(0, 99) < pc, $urandom_range(0, 3),
            $urandom_range(0, 99) < pb, $urandom_range(0, 99) < pn);
      if (b == 17) do_reset();
    end
    ack_mode = 0;
    idle(40);
    @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
